// File: rtl/cc_speedtimer.sv
// Programmable-speed tick generator: a free-running counter compared against a
// per-level threshold (BASE >> level, floor 1), giving a one-cycle active-low tick.
module cc_speedtimer #(
  parameter int DATAWIDTH  = 23,
  parameter int BASE       = 1023,
  parameter int LEVELS     = 4,
  parameter int LEVELWIDTH = 2
) (
  input  logic                  CC_SPEEDTIMER_CLOCK_50,
  input  logic                  CC_SPEEDTIMER_RESET_InHigh,
  input  logic                  CC_SPEEDTIMER_enable_InHigh,
  input  logic                  CC_SPEEDTIMER_clear_InHigh,
  input  logic                  CC_SPEEDTIMER_speedup_InHigh,
  input  logic                  CC_SPEEDTIMER_speeddown_InHigh,
  output logic                  CC_SPEEDTIMER_T0_OutLow,
  output logic [LEVELWIDTH-1:0] CC_SPEEDTIMER_level_OutBUS,
  output logic [DATAWIDTH-1:0]  CC_SPEEDTIMER_count_OutBUS
);

  localparam int TABLESIZE = 2 ** LEVELWIDTH;

  logic [DATAWIDTH-1:0]  countReg, countNext;
  logic [LEVELWIDTH-1:0] levelReg, levelNext;
  logic                  t0Reg, t0Next;
  logic [DATAWIDTH-1:0]  thr;
  logic                  upValid, downValid;

  // Threshold per level is a constant; level codes beyond LEVELS-1 are unreachable.
  logic [TABLESIZE-1:0][DATAWIDTH-1:0] thrTable;

  generate
    for (genvar gi = 0; gi < TABLESIZE; gi++) begin : gThr
      localparam logic [DATAWIDTH-1:0] SHIFTED = DATAWIDTH'(BASE) >> gi;
      assign thrTable[gi] = (SHIFTED == '0) ? DATAWIDTH'(1) : SHIFTED;
    end
  endgenerate

  assign thr = thrTable[levelReg];

  assign upValid   = CC_SPEEDTIMER_speedup_InHigh && !CC_SPEEDTIMER_speeddown_InHigh &&
                     (levelReg < LEVELWIDTH'(LEVELS - 1));
  assign downValid = CC_SPEEDTIMER_speeddown_InHigh && !CC_SPEEDTIMER_speedup_InHigh &&
                     (levelReg != '0);

  always_comb begin
    countNext = countReg;
    levelNext = levelReg;
    t0Next    = 1'b1;
    if (CC_SPEEDTIMER_clear_InHigh) begin
      countNext = '0;
    end else if (upValid) begin
      // A level change restarts the period and suppresses any due tick.
      levelNext = levelReg + LEVELWIDTH'(1);
      countNext = '0;
    end else if (downValid) begin
      levelNext = levelReg - LEVELWIDTH'(1);
      countNext = '0;
    end else if (CC_SPEEDTIMER_enable_InHigh) begin
      if (countReg == thr) begin
        countNext = '0;
        t0Next    = 1'b0;
      end else begin
        countNext = countReg + DATAWIDTH'(1);
      end
    end
  end

  always_ff @(posedge CC_SPEEDTIMER_CLOCK_50 or posedge CC_SPEEDTIMER_RESET_InHigh) begin
    if (CC_SPEEDTIMER_RESET_InHigh) begin
      countReg <= '0;
      levelReg <= '0;
      t0Reg    <= 1'b1;
    end else begin
      countReg <= countNext;
      levelReg <= levelNext;
      t0Reg    <= t0Next;
    end
  end

  assign CC_SPEEDTIMER_T0_OutLow    = t0Reg;
  assign CC_SPEEDTIMER_level_OutBUS = levelReg;
  assign CC_SPEEDTIMER_count_OutBUS = countReg;

endmodule

// File: tb/tb_cc_speedtimer.sv
// Bench for cc_speedtimer: expected tick cycles are queued by the stimulus and
// matched by per-instance monitors; register values are checked directly.
module tb_cc_speedtimer;

  typedef struct {
    int cyc;
    int lvl;
  } tick_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  tick_t qA[$];
  tick_t qB[$];

  logic        rstA = 1'b1, enA = 1'b0, clrA = 1'b0, upA = 1'b0, dnA = 1'b0;
  logic        t0A;
  logic [1:0]  levelA;
  logic [22:0] countA;

  logic        rstB = 1'b1, enB = 1'b0, clrB = 1'b0, upB = 1'b0, dnB = 1'b0;
  logic        t0B;
  logic [1:0]  levelB;
  logic [22:0] countB;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  cc_speedtimer #(.DATAWIDTH(23), .BASE(1023), .LEVELS(4), .LEVELWIDTH(2)) dutA (
    .CC_SPEEDTIMER_CLOCK_50        (clk),
    .CC_SPEEDTIMER_RESET_InHigh    (rstA),
    .CC_SPEEDTIMER_enable_InHigh   (enA),
    .CC_SPEEDTIMER_clear_InHigh    (clrA),
    .CC_SPEEDTIMER_speedup_InHigh  (upA),
    .CC_SPEEDTIMER_speeddown_InHigh(dnA),
    .CC_SPEEDTIMER_T0_OutLow       (t0A),
    .CC_SPEEDTIMER_level_OutBUS    (levelA),
    .CC_SPEEDTIMER_count_OutBUS    (countA)
  );

  cc_speedtimer #(.DATAWIDTH(23), .BASE(3), .LEVELS(4), .LEVELWIDTH(2)) dutB (
    .CC_SPEEDTIMER_CLOCK_50        (clk),
    .CC_SPEEDTIMER_RESET_InHigh    (rstB),
    .CC_SPEEDTIMER_enable_InHigh   (enB),
    .CC_SPEEDTIMER_clear_InHigh    (clrB),
    .CC_SPEEDTIMER_speedup_InHigh  (upB),
    .CC_SPEEDTIMER_speeddown_InHigh(dnB),
    .CC_SPEEDTIMER_T0_OutLow       (t0B),
    .CC_SPEEDTIMER_level_OutBUS    (levelB),
    .CC_SPEEDTIMER_count_OutBUS    (countB)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor for instance A: missed ticks, unexpected ticks, tick timing and level.
  always @(negedge clk) begin
    if (qA.size() > 0 && qA[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL tickA missed: expected at cycle %0d, no tick observed by cycle %0d", qA[0].cyc, cyc);
      void'(qA.pop_front());
    end
    if (t0A == 1'b0) begin
      if (qA.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tickA unexpected: tick at cycle %0d, none expected", cyc);
      end else begin
        tick_t e;
        e = qA.pop_front();
        check("tickA cycle", cyc, e.cyc);
        check("tickA level", int'(levelA), e.lvl);
      end
    end
  end

  always @(negedge clk) begin
    if (qB.size() > 0 && qB[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL tickB missed: expected at cycle %0d, no tick observed by cycle %0d", qB[0].cyc, cyc);
      void'(qB.pop_front());
    end
    if (t0B == 1'b0) begin
      if (qB.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tickB unexpected: tick at cycle %0d, none expected", cyc);
      end else begin
        tick_t e;
        e = qB.pop_front();
        check("tickB cycle", cyc, e.cyc);
        check("tickB level", int'(levelB), e.lvl);
      end
    end
  end

  // One-cycle request on instance A; returns at the negedge after the sampling edge.
  task automatic cycA(input logic up, input logic dn, input logic clr);
    upA = up;
    dnA = dn;
    clrA = clr;
    @(negedge clk);
    upA = 1'b0;
    dnA = 1'b0;
    clrA = 1'b0;
  endtask

  initial begin
    int c0, e3, e5, e7, e8, e9, c1, d;
    repeat (3) @(negedge clk);
    check("reset count", int'(countA), 0);
    check("reset level", int'(levelA), 0);
    check("reset T0", int'(t0A), 1);

    // Level-0 period: ticks after edges 1024 and 2048.
    c0 = cyc;
    rstA = 1'b0;
    enA = 1'b1;
    qA.push_back('{c0 + 1024, 0});
    qA.push_back('{c0 + 2048, 0});
    repeat (2060) @(negedge clk);
    check("count after two periods", int'(countA), 12);

    // Speeddown at level 0 saturates and does not restart.
    cycA(1'b0, 1'b1, 1'b0);
    check("speeddown@0 level", int'(levelA), 0);
    check("speeddown@0 count", int'(countA), 13);

    // Saturating speedup.
    cycA(1'b1, 1'b0, 1'b0);
    check("speedup1 level", int'(levelA), 1);
    check("speedup1 count", int'(countA), 0);
    repeat (19) @(negedge clk);
    cycA(1'b1, 1'b0, 1'b0);
    check("speedup2 level", int'(levelA), 2);
    check("speedup2 count", int'(countA), 0);
    repeat (19) @(negedge clk);
    cycA(1'b1, 1'b0, 1'b0);
    e3 = cyc;
    check("speedup3 level", int'(levelA), 3);
    check("speedup3 count", int'(countA), 0);
    qA.push_back('{e3 + 128, 3});
    repeat (19) @(negedge clk);
    cycA(1'b1, 1'b0, 1'b0);
    check("speedup4 level", int'(levelA), 3);
    check("speedup4 count", int'(countA), 20);
    qA.push_back('{e3 + 256, 3});
    repeat (240) @(negedge clk);
    check("level3 count", int'(countA), 4);

    // Conflicting requests at level 2.
    cycA(1'b0, 1'b1, 1'b0);
    e5 = cyc;
    check("speeddown level", int'(levelA), 2);
    repeat (50) @(negedge clk);
    check("pre-conflict count", int'(countA), 50);
    cycA(1'b1, 1'b1, 1'b0);
    check("conflict level", int'(levelA), 2);
    check("conflict count", int'(countA), 51);
    qA.push_back('{e5 + 256, 2});
    repeat (210) @(negedge clk);

    // Pause, then clear with enable at level 1.
    cycA(1'b0, 1'b1, 1'b0);
    repeat (300) @(negedge clk);
    check("level1", int'(levelA), 1);
    check("count before pause", int'(countA), 300);
    enA = 1'b0;
    repeat (10) @(negedge clk);
    check("count held while paused", int'(countA), 300);
    enA = 1'b1;
    cycA(1'b0, 1'b0, 1'b1);
    e7 = cyc;
    check("count after clear", int'(countA), 0);
    qA.push_back('{e7 + 512, 1});
    repeat (1023) @(negedge clk);
    check("count at threshold", int'(countA), 511);
    cycA(1'b0, 1'b0, 1'b1);
    e8 = cyc;
    check("clear beats tick count", int'(countA), 0);
    qA.push_back('{e8 + 512, 1});
    repeat (520) @(negedge clk);

    // Async reset during a tick at level 2.
    cycA(1'b1, 1'b0, 1'b0);
    e9 = cyc;
    check("level2 before reset", int'(levelA), 2);
    qA.push_back('{e9 + 256, 2});
    repeat (256) @(negedge clk);
    #2 rstA = 1'b1;
    #1;
    check("async reset T0", int'(t0A), 1);
    check("async reset level", int'(levelA), 0);
    check("async reset count", int'(countA), 0);
    repeat (2) @(negedge clk);
    c1 = cyc;
    rstA = 1'b0;
    qA.push_back('{c1 + 1024, 0});
    repeat (1030) @(negedge clk);
    check("level after reset", int'(levelA), 0);

    // Clamped threshold on the BASE=3 instance: period 2 at level 3.
    d = cyc;
    rstB = 1'b0;
    enB = 1'b1;
    upB = 1'b1;
    repeat (3) @(negedge clk);
    upB = 1'b0;
    check("clamp level", int'(levelB), 3);
    check("clamp count", int'(countB), 0);
    for (int k = 0; k < 10; k++) qB.push_back('{d + 5 + 2 * k, 3});
    repeat (21) @(negedge clk);
    enB = 1'b0;
    repeat (5) @(negedge clk);

    check("queue A drained", qA.size(), 0);
    check("queue B drained", qB.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cc_speedtimer.md
# cc_speedtimer

Programmable-speed tick generator for game/animation pacing. It is the parametrised successor of the fixed-constant speed comparator: it contains its own free-running counter and compares it against a threshold chosen from LEVELS speed levels. It emits a one-cycle active-low tick each period, and the level is stepped up or down by single-cycle requests. It sits between the board clock and any state machine that needs a slower, adjustable step enable, for example object movement.

## Interface
- DATAWIDTH, 23: counter and threshold width.
- BASE, 1023: level-0 threshold; level-0 period is BASE+1 cycles.
- LEVELS, 4: number of speed levels, 0..LEVELS-1; must be at least 2.
- LEVELWIDTH, 2: width of the level register; must satisfy 2^LEVELWIDTH ≥ LEVELS.

- CC_SPEEDTIMER_CLOCK_50 input 1: sole clock; all state updates on its rising edge.
- CC_SPEEDTIMER_RESET_InHigh input 1: asynchronous, active-high reset.
- CC_SPEEDTIMER_enable_InHigh input 1: counting enable.
- CC_SPEEDTIMER_clear_InHigh input 1: synchronous restart of the period.
- CC_SPEEDTIMER_speedup_InHigh input 1: one-cycle request for level+1, which gives a faster tick.
- CC_SPEEDTIMER_speeddown_InHigh input 1: one-cycle request for level−1.
- CC_SPEEDTIMER_T0_OutLow output 1: registered tick, low for exactly one cycle per period.
- CC_SPEEDTIMER_level_OutBUS output LEVELWIDTH: current level.
- CC_SPEEDTIMER_count_OutBUS output DATAWIDTH: current counter value.

## Operation
- **Threshold.** thr(L) = BASE >> L, clamped to a minimum of 1. It is computed combinationally from the level register and is DATAWIDTH wide. Period at level L is thr(L)+1 cycles.
- **Reset values.** count = 0, level = 0, T0_OutLow = 1. These are applied immediately on reset assertion, independent of the clock.
- **Per-edge priority**, highest first:
  1. **clear = 1.** count ← 0 and T0 ← 1. Level is unchanged and any speed request in the same cycle is dropped.
  2. **Valid level change.** count ← 0 and T0 ← 1. Level ± 1 takes effect at this edge; no tick is issued at this edge, even if count equalled the old threshold.
     - speedup=1 with speeddown=0 and level < LEVELS−1: level increments.
     - speeddown=1 with speedup=0 and level > 0: level decrements.
  3. **enable = 1 and count == thr(level).** count ← 0 and T0 ← 0 (tick).
  4. **enable = 1 otherwise.** count ← count+1 and T0 ← 1.
  5. **enable = 0.** count holds and T0 ← 1.
- **Ignored speed requests.** Simultaneous speedup and speeddown do nothing. Speedup at level LEVELS−1 and speeddown at level 0 saturate silently. An ignored request does not restart the period; the edge falls through to rules 3–5.
- **Speed changes while paused.** Level changes are accepted while enable = 0.
- **Counter invariant.** count never exceeds thr(level), because every level change zeroes it. Wrap-around of the DATAWIDTH counter therefore cannot occur.
- **Tick spacing.** Since thr ≥ 1, two ticks are never back-to-back; T0 returns high at the edge after a tick.

## Timing
- **First tick after reset**, with enable held high and no requests: count reaches thr at edge thr. T0 goes low after edge thr+1 and high again after edge thr+2.
- **Steady state:** the falling edges of T0 are exactly thr(level)+1 cycles apart.
- **Restart latency for clear and level changes.** The edge that samples the request is the new period's start. The next tick occurs thr(new)+1 edges later, with T0 low after that edge.
- **Output timing.** level_OutBUS and count_OutBUS are registers and update at the same edge as the internal state.
- **Reset mid-period.** Any tick in progress is aborted at once: T0 goes to 1 and no partial period is carried over.

## Test plan
- **Reset and level-0 period.** With defaults, release reset and hold enable=1. T0 is low for 1 cycle after edge 1024, then again after edge 2048; level_OutBUS = 0 throughout.
- **Saturating speedup.** Pulse speedup 4 times, 20 cycles apart. Level goes 1, 2, 3, 3 and the period becomes 128 cycles (thr = 127). Count is zeroed at each of the first three pulses, but not at the fourth.
- **Conflicting requests and speeddown at 0.**
  - At level 2 with count = 50, assert speedup and speeddown together. Level stays 2 and count becomes 51.
  - At level 0, pulse speeddown. Level stays 0 and there is no restart.
- **Enable, clear and tick priority.**
  - At level 1 with count = 300, drop enable for 10 cycles. Count holds at 300 and T0 stays 1.
  - Then assert clear together with enable. Count becomes 0 and the next tick follows 512 edges later.
  - Clear in the same cycle that count == thr produces no tick.
- **Threshold clamp.** With BASE=3 and LEVELS=4, go to level 3 (3 >> 3 = 0, clamped to 1). The tick period is 2 cycles with T0 low every other cycle, never two consecutive lows.
- **Asynchronous reset mid-operation.** Assert reset during the cycle T0 is low, at level 2. T0 goes to 1, level and count go to 0, without waiting for a clock edge. After release, the next tick follows the level-0 timing.
